// File: rtl/if_fetch_unit.sv
// Instruction-fetch unit: drives the instruction ROM, tags each returned word with its
// address and buffers it in a small in-order FIFO feeding decode over valid/ready.
module if_fetch_unit #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        rom_ce_o,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_inst_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_addr_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  input  logic        inst_ready_i
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] Depth = CntW'(FIFO_DEPTH);

  logic [31:0]     pc_q, pc_d;
  logic            run_q;
  logic [CntW-1:0] count_q, count_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]     mem_inst_q [FIFO_DEPTH];
  logic [31:0]     mem_addr_q [FIFO_DEPTH];

  logic pop;
  logic fetch_en;

  assign inst_valid_o = (count_q != '0);
  assign pop          = inst_valid_o & inst_ready_i;
  // A pop this cycle frees a slot, so a full FIFO can still accept a fetch.
  assign fetch_en     = run_q & ~redirect_i & ((count_q < Depth) | pop);

  assign rom_ce_o    = fetch_en;
  assign rom_addr_o  = pc_q;
  assign inst_o      = inst_valid_o ? mem_inst_q[rd_ptr_q] : 32'h0;
  assign inst_addr_o = inst_valid_o ? mem_addr_q[rd_ptr_q] : 32'h0;

  always_comb begin
    pc_d     = pc_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (redirect_i) begin
      pc_d     = redirect_addr_i & 32'hFFFF_FFFC;
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (fetch_en) begin
        pc_d     = pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      count_d = count_q + CntW'(fetch_en) - CntW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_ADDR;
      run_q    <= 1'b0;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      pc_q     <= pc_d;
      run_q    <= 1'b1;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_inst_q[i] <= 32'h0;
        mem_addr_q[i] <= 32'h0;
      end
    end else if (fetch_en) begin
      mem_inst_q[wr_ptr_q] <= rom_inst_i;
      mem_addr_q[wr_ptr_q] <= pc_q;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios plus random ready/redirect traffic checked
// cycle by cycle against a queue-based model of the fetch stream.
module tb_if_fetch_unit;

  localparam logic [31:0] ResetAddr = 32'h0000_0000;
  localparam int unsigned Depth     = 2;

  logic        clk;
  logic        rst_n;
  logic        rom_ce_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_inst_i;
  logic        redirect_i;
  logic [31:0] redirect_addr_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_ready_i;

  int checks   = 0;
  int failures = 0;

  if_fetch_unit #(
    .RESET_ADDR(ResetAddr),
    .FIFO_DEPTH(Depth)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rom_ce_o       (rom_ce_o),
    .rom_addr_o     (rom_addr_o),
    .rom_inst_i     (rom_inst_i),
    .redirect_i     (redirect_i),
    .redirect_addr_i(redirect_addr_i),
    .inst_valid_o   (inst_valid_o),
    .inst_o         (inst_o),
    .inst_addr_o    (inst_addr_o),
    .inst_ready_i   (inst_ready_i)
  );

  // ROM: word k holds 0x1000_0000 + k.
  function automatic logic [31:0] rom_word(input logic [31:0] addr);
    return 32'h1000_0000 + (addr >> 2);
  endfunction

  assign rom_inst_i = rom_word(rom_addr_o);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: fetch pc, running flag, and the buffered stream of {addr, inst}.
  logic [31:0] m_pc;
  logic        m_run;
  logic [63:0] m_q[$];

  task automatic model_reset();
    m_pc  = ResetAddr;
    m_run = 1'b0;
    m_q.delete();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare all outputs with the model, then advance the model.
  task automatic cycle(input logic rdy, input logic redir, input logic [31:0] raddr);
    logic        e_valid;
    logic        e_pop;
    logic        e_ce;
    logic [31:0] e_inst;
    logic [31:0] e_iaddr;
    logic [63:0] head;
    inst_ready_i    = rdy;
    redirect_i      = redir;
    redirect_addr_i = raddr;
    #3;
    e_valid = (m_q.size() != 0);
    head    = e_valid ? m_q[0] : 64'h0;
    e_iaddr = head[63:32];
    e_inst  = head[31:0];
    e_pop   = e_valid & rdy;
    e_ce    = m_run & !redir & ((m_q.size() < Depth) | e_pop);
    chk("rom_ce", 32'(rom_ce_o), 32'(e_ce));
    chk("rom_addr", rom_addr_o, m_pc);
    chk("inst_valid", 32'(inst_valid_o), 32'(e_valid));
    chk("inst", inst_o, e_inst);
    chk("inst_addr", inst_addr_o, e_iaddr);
    @(posedge clk);
    #1;
    if (rst_n) begin
      if (redir) begin
        m_q.delete();
        m_pc = {raddr[31:2], 2'b00};
      end else begin
        if (e_pop) void'(m_q.pop_front());
        if (e_ce) begin
          m_q.push_back({m_pc, rom_word(m_pc)});
          m_pc = m_pc + 32'd4;
        end
      end
      m_run = 1'b1;
    end
  endtask

  initial begin
    rst_n           = 1'b0;
    inst_ready_i    = 1'b1;
    redirect_i      = 1'b0;
    redirect_addr_i = 32'h0;
    model_reset();
    #1;

    // Reset state, including a redirect attempted while in reset.
    cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 32'h0000_0400);

    // 1: release and stream with ready held high.
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 32'h0);

    // 2: restart at 0, then back-pressure for 5 cycles, then drain.
    cycle(1'b1, 1'b1, 32'h0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 32'h0);
    chk("bp_pc_hold", rom_addr_o, 32'h0000_0008);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 32'h0);

    // 3: redirect while full (ready low), then hold ready low a little.
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 32'h0000_0103);
    chk("redir_addr_n1", rom_addr_o, 32'h0000_0100);
    cycle(1'b0, 1'b0, 32'h0);
    chk("redir_head_n2", inst_addr_o, 32'h0000_0100);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 32'h0);

    // 4: redirect coinciding with a pop; back-to-back redirects (last wins).
    cycle(1'b1, 1'b1, 32'h0000_0200);
    cycle(1'b1, 1'b1, 32'h0000_0300);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 32'h0);

    // 5: address wrap at the top of the space.
    cycle(1'b1, 1'b1, 32'hFFFF_FFF8);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 32'h0);

    // 6: asynchronous reset with a full FIFO.
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(inst_valid_o), 32'h0);
    chk("async_rst_ce", 32'(rom_ce_o), 32'h0);
    chk("async_rst_inst", inst_o, 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    cycle(1'b0, 1'b0, 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 32'h0);

    // Random ready / redirect traffic.
    for (int i = 0; i < 400; i++) begin
      logic        rdy;
      logic        redir;
      logic [31:0] ra;
      rdy   = ($urandom_range(0, 3) != 0);
      redir = ($urandom_range(0, 9) == 0);
      ra    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                          : $urandom;
      cycle(rdy, redir, ra);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
